// File: rtl/waterfall_pkg.sv
// Shared definitions for the key controller: clear-sequence FSM states and
// the default debounce window (20 ms at 50 MHz).
package waterfall_pkg;

  localparam int DEB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    RELEASE = 2'd3
  } clr_state_e;

endpackage

// File: rtl/key_ctrl_if.sv
// Bundle of the pushbutton inputs, the 1 Hz count clock and the control
// outputs that the key controller hands to the counter stage.
interface key_ctrl_if;

  logic key_stop_n;
  logic key_clr_n;
  logic key_mode_n;
  logic clk_1hz;
  logic stop_n;
  logic clr_n;
  logic M;
  logic clr_busy;

  // Side that owns the buttons and the count clock, and observes the controls
  modport master (
    output key_stop_n, key_clr_n, key_mode_n, clk_1hz,
    input  stop_n, clr_n, M, clr_busy
  );

  // Side that implements the controller
  modport slave (
    input  key_stop_n, key_clr_n, key_mode_n, clk_1hz,
    output stop_n, clr_n, M, clr_busy
  );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-flop synchronizer, saturating stability counter
// and a registered one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
  import waterfall_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Next-state: shift synchronizer, count mismatching samples, flip level
  // once the new value has been held for the whole window
  always_comb begin
    sync_d  = {sync_q[0], key_n};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  // State registers; released button reads as 1 after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_ctrl.sv
// Run/stop, mode and clear control for the counter stage. Stop and mode
// presses toggle registered levels; a clear press holds clr_n low until a
// complete rising edge of the 1 Hz count clock has been seen.
module key_ctrl
  import waterfall_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_stop_n,
  input  logic key_clr_n,
  input  logic key_mode_n,
  input  logic clk_1hz,
  output logic stop_n,
  output logic clr_n,
  output logic M,
  output logic clr_busy
);

  logic       stop_press, clr_press, mode_press;
  logic [1:0] hz_sync_q, hz_sync_d;
  clr_state_e state_q, state_d;
  logic       stop_n_q, stop_n_d;
  logic       m_q, m_d;
  logic       clr_n_q, clr_n_d;
  logic       clr_busy_q, clr_busy_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_stop_n),
    .press (stop_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_clr_n),
    .press (clr_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  // Next-state and registered-output decode; clear presses outside IDLE drop
  always_comb begin
    hz_sync_d = {hz_sync_q[0], clk_1hz};
    state_d   = state_q;
    unique case (state_q)
      IDLE:    if (clr_press)     state_d = WAIT_LO;
      WAIT_LO: if (!hz_sync_q[1]) state_d = WAIT_HI;
      WAIT_HI: if (hz_sync_q[1])  state_d = RELEASE;
      RELEASE:                    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    clr_n_d    = !((state_d == WAIT_LO) || (state_d == WAIT_HI));
    clr_busy_d = (state_d != IDLE);
    stop_n_d   = stop_n_q ^ stop_press;
    m_d        = m_q ^ mode_press;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_sync_q  <= 2'b11;
      state_q    <= IDLE;
      stop_n_q   <= 1'b1;
      m_q        <= 1'b0;
      clr_n_q    <= 1'b1;
      clr_busy_q <= 1'b0;
    end else begin
      hz_sync_q  <= hz_sync_d;
      state_q    <= state_d;
      stop_n_q   <= stop_n_d;
      m_q        <= m_d;
      clr_n_q    <= clr_n_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign stop_n   = stop_n_q;
  assign M        = m_q;
  assign clr_n    = clr_n_q;
  assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: a behavioural model predicts every output change
// (cycle and value) into a queue; a negedge monitor pops and compares.
module tb_key_ctrl;

  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_ctrl_if ifc ();

  key_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_stop_n (ifc.key_stop_n),
    .key_clr_n  (ifc.key_clr_n),
    .key_mode_n (ifc.key_mode_n),
    .clk_1hz    (ifc.clk_1hz),
    .stop_n     (ifc.stop_n),
    .clr_n      (ifc.clr_n),
    .M          (ifc.M),
    .clr_busy   (ifc.clr_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int       cyc;
    logic [3:0] val;
  } exp_t;
  exp_t sbq[$];

  // ---------------- reference model ----------------
  // index 0 stop, 1 clear, 2 mode, 3 count clock
  bit       d1 [4];
  bit       d2 [4];
  bit       win [3][DEB];
  bit       mlev [3];
  bit       mpend [3];
  bit       m_stop, m_mode, m_busy, m_low, m_seen_low;
  logic [3:0] m_prev;

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) begin
      d1[i] = 1'b1;
      d2[i] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      mlev[k]  = 1'b1;
      mpend[k] = 1'b0;
      for (int j = 0; j < DEB; j++) win[k][j] = 1'b1;
    end
    m_stop = 1'b1; m_mode = 1'b0; m_busy = 1'b0; m_low = 1'b0; m_seen_low = 1'b0;
    m_prev = 4'b1100;
    sbq.delete();
  endtask

  task automatic mdl_step();
    bit raw [4];
    bit syn [4];
    bit all_diff;
    logic [3:0] cur;
    raw[0] = ifc.key_stop_n; raw[1] = ifc.key_clr_n;
    raw[2] = ifc.key_mode_n; raw[3] = ifc.clk_1hz;
    for (int i = 0; i < 4; i++) begin
      syn[i] = d2[i];
      d2[i]  = d1[i];
      d1[i]  = raw[i];
    end
    // presses detected last edge take effect now
    if (mpend[0]) m_stop = !m_stop;
    if (mpend[2]) m_mode = !m_mode;
    if (m_busy && !m_low) begin
      m_busy = 1'b0;
    end else if (m_low) begin
      if (!m_seen_low) begin
        if (!syn[3]) m_seen_low = 1'b1;
      end else if (syn[3]) begin
        m_low = 1'b0;
      end
    end else if (mpend[1]) begin
      m_busy = 1'b1; m_low = 1'b1; m_seen_low = 1'b0;
    end
    // debounced level flips when the last DEB synchronized samples all differ
    for (int k = 0; k < 3; k++) begin
      for (int j = DEB - 1; j > 0; j--) win[k][j] = win[k][j-1];
      win[k][0] = syn[k];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (win[k][j] == mlev[k]) all_diff = 1'b0;
      mpend[k] = 1'b0;
      if (all_diff) begin
        mlev[k]  = !mlev[k];
        mpend[k] = (mlev[k] == 1'b0);
      end
    end
    cur = {m_stop, !m_low, m_mode, m_busy};
    if (cur != m_prev) sbq.push_back('{cyc, cur});
    m_prev = cur;
  endtask

  // Model advances with the DUT, resets with it
  always @(posedge clk or posedge rst) begin
    cyc++;
    if (rst) mdl_reset();
    else     mdl_step();
  end

  // ---------------- monitor ----------------
  bit         mon_en = 1'b0;
  logic [3:0] mon_prev;

  // Pop one expectation for every output change; flag overdue expectations
  always @(negedge clk) begin
    logic [3:0] cur;
    exp_t e;
    if (mon_en && !rst) begin
      cur = {ifc.stop_n, ifc.clr_n, ifc.M, ifc.clr_busy};
      if (cur !== mon_prev) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, mon_prev);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            bad++;
            $display("FAIL out_change cyc=%0d got=%b want=%b at cyc=%0d", cyc, cur, e.val, e.cyc);
          end
        end
        mon_prev = cur;
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL missing_change cyc=%0d got=%b want=%b", cyc, cur, e.val);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    mon_prev = 4'b1100;
    mon_en   = 1'b1;
    if (check) begin
      chk("rst_stop_n", ifc.stop_n, 1'b1);
      chk("rst_clr_n", ifc.clr_n, 1'b1);
      chk("rst_m", ifc.M, 1'b0);
      chk("rst_clr_busy", ifc.clr_busy, 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_k [4];
    ifc.key_stop_n = 1'b1;
    ifc.key_clr_n  = 1'b1;
    ifc.key_mode_n = 1'b1;
    ifc.clk_1hz    = 1'b1;
    do_reset(1'b1);

    // stop toggle: exact latency, then second press restores
    tick(2);
    ifc.key_stop_n = 1'b0;
    repeat (10) @(posedge clk);
    #3 chk("stop_c10_still_1", ifc.stop_n, 1'b1);
    @(posedge clk);
    #3 chk("stop_c11_low", ifc.stop_n, 1'b0);
    tick(9);
    ifc.key_stop_n = 1'b1;
    tick(15);
    ifc.key_stop_n = 1'b0;
    tick(20);
    ifc.key_stop_n = 1'b1;
    tick(15);
    chk("stop_second_press", ifc.stop_n, 1'b1);

    // debounce rejection: five 7-cycle pulses
    for (int i = 0; i < 5; i++) begin
      ifc.key_mode_n = 1'b0;
      tick(7);
      ifc.key_mode_n = 1'b1;
      tick(3);
    end
    tick(15);
    chk("mode_glitch_m", ifc.M, 1'b0);

    // clear handshake
    ifc.key_clr_n = 1'b0;
    tick(12);
    chk("clr_low_after_press", ifc.clr_n, 1'b0);
    chk("clr_busy_after_press", ifc.clr_busy, 1'b1);
    ifc.key_clr_n = 1'b1;
    tick(3);
    ifc.clk_1hz = 1'b0;
    tick(4);
    ifc.clk_1hz = 1'b1;
    repeat (2) @(posedge clk);
    #3 chk("clr_low_before_rise_seen", ifc.clr_n, 1'b0);
    @(posedge clk);
    #3 chk("clr_released", ifc.clr_n, 1'b1);
    chk("clr_busy_in_release", ifc.clr_busy, 1'b1);
    @(posedge clk);
    #3 chk("clr_busy_dropped", ifc.clr_busy, 1'b0);
    tick(15);

    // re-press while busy is dropped; clock held high means no timeout
    ifc.key_clr_n = 1'b0;
    tick(12);
    chk("clr2_busy", ifc.clr_busy, 1'b1);
    ifc.key_clr_n = 1'b1;
    tick(12);
    ifc.key_clr_n = 1'b0;
    tick(12);
    chk("clr2_still_low", ifc.clr_n, 1'b0);
    ifc.key_clr_n = 1'b1;
    tick(12);
    ifc.clk_1hz = 1'b0;
    tick(5);
    chk("clr2_wait_hi_low", ifc.clr_n, 1'b0);
    // abort mid-clear
    do_reset(1'b1);
    tick(20);
    chk("no_queued_clear", ifc.clr_busy, 1'b0);

    // simultaneous press with count clock low, then one rising edge
    ifc.key_stop_n = 1'b0;
    ifc.key_clr_n  = 1'b0;
    ifc.key_mode_n = 1'b0;
    repeat (11) @(posedge clk);
    #3 chk("sim_stop_n", ifc.stop_n, 1'b0);
    chk("sim_m", ifc.M, 1'b1);
    chk("sim_clr_n", ifc.clr_n, 1'b0);
    tick(5);
    ifc.clk_1hz = 1'b1;
    repeat (3) @(posedge clk);
    #3 chk("sim_clr_released", ifc.clr_n, 1'b1);
    chk("sim_stop_kept", ifc.stop_n, 1'b0);
    tick(1);
    ifc.key_stop_n = 1'b1;
    ifc.key_clr_n  = 1'b1;
    tick(15);

    // key held through reset: one event after release of reset
    do_reset(1'b0);
    tick(20);
    ifc.key_mode_n = 1'b1;
    tick(15);
    chk("held_through_reset_m", ifc.M, 1'b1);

    // randomized buttons and count clock, with a reset in the middle
    for (int i = 0; i < 4; i++) cnt_k[i] = $urandom_range(1, 30);
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
        if (cnt_k[i] == 0) begin
          case (i)
            0: ifc.key_stop_n = ~ifc.key_stop_n;
            1: ifc.key_clr_n  = ~ifc.key_clr_n;
            2: ifc.key_mode_n = ~ifc.key_mode_n;
            default: ifc.clk_1hz = ~ifc.clk_1hz;
          endcase
          if (i == 3)                          cnt_k[i] = $urandom_range(1, 30);
          else if ($urandom_range(0, 3) == 0)  cnt_k[i] = $urandom_range(1, 7);
          else                                 cnt_k[i] = $urandom_range(8, 30);
        end else begin
          cnt_k[i]--;
        end
      end
      tick(1);
    end
    ifc.key_stop_n = 1'b1;
    ifc.key_clr_n  = 1'b1;
    ifc.key_mode_n = 1'b1;
    ifc.clk_1hz    = 1'b1;
    tick(40);

    chk("end_stop_n", ifc.stop_n, m_prev[3]);
    chk("end_clr_n", ifc.clr_n, m_prev[2]);
    chk("end_m", ifc.M, m_prev[1]);
    chk("end_clr_busy", ifc.clr_busy, m_prev[0]);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL queue_drained got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
